sr_flip_flop: RTL and testbench

//   Clocked SR flip-flop: Set/Reset inputs sampled on the rising CLK edge drive
//   a registered output Q and its complement Qn. A generic storage primitive for

---
 rtl/sr_pkg.sv | 18 +
 rtl/sr_cell.sv | 40 ++++
 rtl/sr_flip_flop.sv | 29 ++
 tb/tb_sr_flip_flop.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: S=R=1 policy encodings and the per-bit SR next-state function
package sr_pkg;

    localparam int SR_HOLD    = 0;
    localparam int SR_SET_DOM = 1;
    localparam int SR_RST_DOM = 2;
    localparam int SR_TOGGLE  = 3;

    // Unknown policy codes fall through to hold
    function automatic logic next_q(input logic s, input logic r, input logic q, input int mode);
        return (s && r) ? ((mode == SR_SET_DOM) ? 1'b1 :
                           (mode == SR_RST_DOM) ? 1'b0 :
                           (mode == SR_TOGGLE)  ? ~q   : q) :
               s ? 1'b1 :
               r ? 1'b0 : q;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// sr_cell: one clocked SR bit with async reset, complement output and S=R=1 flag
module sr_cell
    import sr_pkg::*;
#(
    parameter int SR_MODE = SR_HOLD
) (
    input  logic CLK,
    input  logic RST,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn,
    output logic invalid
);

    logic q_d, q_q;
    logic invalid_d, invalid_q;

    // Next state from the SR truth table; flag the forbidden input combination
    always_comb begin
        q_d       = next_q(s, r, q_q, SR_MODE);
        invalid_d = s & r;
    end

    // State register, cleared immediately on RST without waiting for an edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q       <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            invalid_q <= invalid_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign invalid = invalid_q;

endmodule

// File: rtl/sr_flip_flop.sv
// sr_flip_flop: WIDTH independent clocked SR bits with configurable S=R=1 policy
module sr_flip_flop
    import sr_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int SR_MODE = SR_HOLD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] INVALID
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_cell #(.SR_MODE(SR_MODE)) u_cell (
            .CLK     (CLK),
            .RST     (RST),
            .s       (S[i]),
            .r       (R[i]),
            .q       (Q[i]),
            .qn      (Qn[i]),
            .invalid (INVALID[i])
        );
    end

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb_sr_flip_flop: directed checks of the SR flip-flop across policies and widths
module tb_sr_flip_flop;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] s, r, q, qn, inv;
    logic [3:0] s4, r4, q4, qn4, inv4;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    // Bits 0..3 use SR_MODE 0..3; bit 4 uses out-of-range mode 5 (must hold)
    for (genvar k = 0; k < 5; k++) begin : g_m
        sr_flip_flop #(.WIDTH(1), .SR_MODE(k == 4 ? 5 : k)) u_dut (
            .CLK     (clk),
            .RST     (rst),
            .S       (s[k]),
            .R       (r[k]),
            .Q       (q[k]),
            .Qn      (qn[k]),
            .INVALID (inv[k])
        );
    end

    sr_flip_flop #(.WIDTH(4), .SR_MODE(0)) u_dut4 (
        .CLK     (clk),
        .RST     (rst),
        .S       (s4),
        .R       (r4),
        .Q       (q4),
        .Qn      (qn4),
        .INVALID (inv4)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [1:0] v2 [7] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    bit         q2 [7] = '{1, 0, 0, 0, 1, 0, 0};
    bit         i2 [7] = '{0, 0, 1, 0, 0, 0, 1};
    logic [1:0] v5 [4] = '{2'b10, 2'b11, 2'b01, 2'b11};
    bit         q5 [4] = '{1, 1, 0, 0};

    initial begin
        s = '0; r = '0; s4 = '0; r4 = '0;
        #1;
        check("rst_q",    4'(q[0]),   4'd0);
        check("rst_qn",   4'(qn[0]),  4'd1);
        check("rst_inv",  4'(inv[0]), 4'd0);
        check("rst_q4",   q4,         4'h0);
        check("rst_qn4",  qn4,        4'hf);
        #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            {s[0], r[0]} = v2[i];
            @(posedge clk); #1;
            check($sformatf("seq%0d_q", i),   4'(q[0]),   4'(q2[i]));
            check($sformatf("seq%0d_qn", i),  4'(qn[0]),  4'(!q2[i]));
            check($sformatf("seq%0d_inv", i), 4'(inv[0]), 4'(i2[i]));
        end
        @(negedge clk);
        s[0] = 1'b0; r[0] = 1'b0;
        s[3:1] = 3'b111; r[3:1] = 3'b111;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            check($sformatf("setdom%0d", e), 4'(q[1]),   4'd1);
            check($sformatf("rstdom%0d", e), 4'(q[2]),   4'd0);
            check($sformatf("toggle%0d", e), 4'(q[3]),   4'(e == 0));
            check($sformatf("tgl_qn%0d", e), 4'(qn[3]),  4'(e != 0));
            check($sformatf("inv13_%0d", e), 4'(inv[3:1]), 4'b0111);
        end
        @(negedge clk);
        s[3:1] = '0; r[3:1] = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {s[4], r[4]} = v5[i];
            @(posedge clk); #1;
            check($sformatf("mode5_%0d", i), 4'(q[4]), 4'(q5[i]));
        end
        @(negedge clk);
        s[4] = 1'b0; r[4] = 1'b0;
        s[0] = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_q", 4'(q[0]), 4'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_q",   4'(q[0]),   4'd0);
        check("arst_qn",  4'(qn[0]),  4'd1);
        check("arst_inv", 4'(inv[0]), 4'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_q", 4'(q[0]), 4'd1);
        @(negedge clk);
        s[0] = 1'b0; r[0] = 1'b1;
        @(posedge clk); #1;
        check("clr_q", 4'(q[0]), 4'd0);
        r[0] = 1'b0;
        s[0] = 1'b1;
        #3;
        check("glitch_mid", 4'(q[0]), 4'd0);
        s[0] = 1'b0;
        @(posedge clk); #1;
        check("glitch_q", 4'(q[0]), 4'd0);
        @(negedge clk);
        s4 = 4'b0101; r4 = 4'b0011;
        @(posedge clk); #1;
        check("w4_q",   q4,   4'b0100);
        check("w4_qn",  qn4,  4'b1011);
        check("w4_inv", inv4, 4'b0001);
        @(negedge clk);
        s4 = 4'b0000; r4 = 4'b0000;
        @(posedge clk); #1;
        check("w4_hold_q",   q4,   4'b0100);
        check("w4_hold_inv", inv4, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
